// File: rtl/modmul_arb.sv
// modmul_arb: round-robin front end for one shared pipelined Kyber
// modular multiplier, with a latency-matched tag pipeline and response port.
module modmul_arb #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [12*N-1:0]   req_a,
    input  logic [12*N-1:0]   req_b,
    output logic [11:0]       mul_a,
    output logic [11:0]       mul_b,
    input  logic [11:0]       mul_r,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [11:0]       rsp_r,
    output logic              busy
);

    logic [IDW-1:0]           r_ptr;
    logic [LAT-1:0]           r_tag_v;
    logic [LAT-1:0][IDW-1:0]  r_tag_id;

    logic                     w_any;
    logic                     w_fire;
    logic [IDW-1:0]           w_gnt;

    // Pick the first valid requester scanning upward from the pointer.
    always_comb begin : grant_sel
        int k;
        w_any = 1'b0;
        w_gnt = '0;
        k     = 0;
        for (int j = N - 1; j >= 0; j--) begin
            k = int'(r_ptr) + j;
            if (k >= N) k = k - N;
            if (req_valid[k]) begin
                w_any = 1'b1;
                w_gnt = IDW'(k);
            end
        end
    end

    // No grant may be issued while reset is held.
    assign w_fire    = w_any & rst;
    assign req_ready = w_fire ? (N'(1) << w_gnt) : '0;
    assign mul_a     = w_fire ? req_a[12*int'(w_gnt) +: 12] : 12'd0;
    assign mul_b     = w_fire ? req_b[12*int'(w_gnt) +: 12] : 12'd0;

    // Advance the pointer past each winner and shift tags along with the multiplier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            if (w_fire) begin
                r_ptr <= (w_gnt == IDW'(N - 1)) ? '0 : w_gnt + IDW'(1);
            end
            r_tag_v[0]  <= w_fire;
            r_tag_id[0] <= w_gnt;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    // Capture the multiplier result when the last tag stage says it is ours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_r     <= '0;
        end else begin
            rsp_valid <= r_tag_v[LAT-1];
            if (r_tag_v[LAT-1]) begin
                rsp_id <= r_tag_id[LAT-1];
                rsp_r  <= mul_r;
            end
        end
    end

    assign busy = (|r_tag_v) | rsp_valid;

endmodule

// File: tb/tb_modmul_arb.sv
// tb_modmul_arb: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the arbiter and response schedule.
module tb_modmul_arb;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 3;
    localparam int Q   = 3329;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [12*N-1:0]   req_a = '0;
    logic [12*N-1:0]   req_b = '0;
    logic [11:0]       mul_a;
    logic [11:0]       mul_b;
    logic [11:0]       mul_r;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [11:0]       rsp_r;
    logic              busy;

    always #5 clk = ~clk;

    modmul_arb #(.N(N), .IDW(IDW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_r     (mul_r),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .busy      (busy)
    );

    // Behavioural multiplier: product mod q appears LAT cycles after presentation.
    logic [11:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= 12'((int'(mul_a) * int'(mul_b)) % Q);
        for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
    end
    assign mul_r = mp[LAT-1];

    typedef struct {
        int due;
        int id;
        int r;
    } exp_t;

    typedef struct {
        logic [N-1:0]    v;
        logic [N-1:0]    rdy;
        logic [12*N-1:0] a;
        logic [12*N-1:0] b;
        int              cid;
        int              cr;
    } vec_t;

    exp_t         q[$];
    int           m_ptr = 0;
    int           cyc = 0;
    int           e_id = 0;
    int           e_r = 0;
    int           m_last_g = -1;
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] s_rdy;
    int           lastr [N];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int opa(input int i);
        return int'(req_a[12*i +: 12]);
    endfunction

    function automatic int opb(input int i);
        return int'(req_b[12*i +: 12]);
    endfunction

    function automatic logic [12*N-1:0] pk(input int x0, input int x1,
                                           input int x2, input int x3);
        return {12'(x3), 12'(x2), 12'(x1), 12'(x0)};
    endfunction

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] rdy,
                                input logic [12*N-1:0] a, input logic [12*N-1:0] b,
                                input int cid, input int cr);
        vec_t t;
        t.v = v; t.rdy = rdy; t.a = a; t.b = b; t.cid = cid; t.cr = cr;
        return t;
    endfunction

    // One clock: check the DUT mid-cycle against the model, then advance the model.
    task automatic cycle();
        int           g;
        int           k;
        logic [N-1:0] er;
        logic         ev;
        exp_t         it;
        @(negedge clk);
        g = -1;
        for (int j = 0; j < N; j++) begin
            k = (m_ptr + j) % N;
            if (g < 0 && req_valid[k]) g = k;
        end
        er = (g >= 0) ? (N'(1) << g) : '0;
        s_rdy = req_ready;
        chk("ready", int'(req_ready), int'(er));
        chk("mul_a", int'(mul_a), (g >= 0) ? opa(g) : 0);
        chk("mul_b", int'(mul_b), (g >= 0) ? opb(g) : 0);
        chk("busy", int'(busy), int'(q.size() > 0));
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (ev) begin
            e_id = q[0].id;
            e_r  = q[0].r;
            void'(q.pop_front());
        end
        chk("rsp_valid", int'(rsp_valid), int'(ev));
        chk("rsp_id", int'(rsp_id), e_id);
        chk("rsp_r", int'(rsp_r), e_r);
        if (rsp_valid) lastr[rsp_id] = int'(rsp_r);
        m_last_g = g;
        if (g >= 0) begin
            it.due = cyc + LAT + 1;
            it.id  = g;
            it.r   = (opa(g) * opb(g)) % Q;
            q.push_back(it);
            m_ptr = (g + 1) % N;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one cycle with requests pending and check every output.
    task automatic do_reset(input logic [N-1:0] v);
        rst = 1'b0;
        req_valid = v;
        @(negedge clk);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_mul_a", int'(mul_a), 0);
        chk("rst_mul_b", int'(mul_b), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_r", int'(rsp_r), 0);
        chk("rst_busy", int'(busy), 0);
        q.delete();
        m_ptr = 0;
        e_id = 0;
        e_r = 0;
        cyc++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
    endtask

    vec_t         tbl[$];
    logic [N-1:0] pend;
    int           pa [N];
    int           pb [N];

    initial begin
        logic [12*N-1:0] fa, fb, za, zb;
        fa = pk(1234, 100, 3000, 3328);
        fb = pk(2, 200, 3000, 2);
        za = pk(7, 0, 9, 11);
        zb = pk(5, 2000, 3, 1);

        // Fairness: full contention, strict rotation.
        for (int r = 0; r < 8; r++)
            tbl.push_back(mk(4'b1111, 4'(1 << (r % 4)), fa, fb, -1, 0));
        for (int r = 0; r < 6; r++)
            tbl.push_back(mk(4'b0000, 4'b0000, fa, fb,
                             (r == 4) ? 0 : ((r == 5) ? 3 : -1),
                             (r == 4) ? 2468 : 3327));
        // Pointer wrap: grant 2, then 3 wins over 1, then 1.
        tbl.push_back(mk(4'b0100, 4'b0100, fa, fb, -1, 0));
        tbl.push_back(mk(4'b1010, 4'b1000, fa, fb, -1, 0));
        tbl.push_back(mk(4'b0010, 4'b0010, fa, fb, -1, 0));
        for (int r = 0; r < 5; r++)
            tbl.push_back(mk(4'b0000, 4'b0000, fa, fb, -1, 0));
        // Idle gaps: issues at relative cycles 0, 2 and 5.
        for (int r = 0; r < 11; r++) begin
            if (r == 0 || r == 2 || r == 5)
                tbl.push_back(mk(4'b0001, 4'b0001,
                                 pk(r + 10, 0, 0, 0), pk(r + 300, 0, 0, 0), -1, 0));
            else
                tbl.push_back(mk(4'b0000, 4'b0000, fa, fb, -1, 0));
        end
        // Zero operand from requester 1 alone.
        tbl.push_back(mk(4'b0010, 4'b0010, za, zb, -1, 0));
        for (int r = 0; r < 5; r++)
            tbl.push_back(mk(4'b0000, 4'b0000, za, zb, (r == 4) ? 1 : -1, 0));

        do_reset(4'b1111);

        // Single op: 3328*3328 mod q = 1.
        req_a = pk(3328, 0, 0, 0);
        req_b = pk(3328, 0, 0, 0);
        req_valid = 4'b0001;
        cycle();
        chk("single_rdy", int'(s_rdy), 1);
        req_valid = '0;
        repeat (5) cycle();
        chk("single_r", int'(rsp_r), 1);
        chk("single_id", int'(rsp_id), 0);

        do_reset('0);

        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            req_a = tbl[i].a;
            req_b = tbl[i].b;
            cycle();
            chk("tbl_rdy", int'(s_rdy), int'(tbl[i].rdy));
            if (tbl[i].cid >= 0)
                chk("tbl_result", lastr[tbl[i].cid], tbl[i].cr);
        end

        // Reset mid-flight: three back-to-back ops, reset after the second response.
        req_a = pk(5, 6, 7, 0);
        req_b = pk(11, 12, 13, 0);
        req_valid = 4'b0111;
        repeat (3) cycle();
        req_valid = '0;
        repeat (3) cycle();
        do_reset(4'b0111);
        repeat (6) cycle();
        req_valid = 4'b1111;
        cycle();
        chk("post_rst_grant", int'(s_rdy), 1);
        req_valid = '0;
        repeat (6) cycle();

        // Random traffic with requesters that hold until granted.
        pend = '0;
        for (int i = 0; i < N; i++) begin
            pa[i] = 0;
            pb[i] = 0;
        end
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pa[i] = int'($urandom_range(0, Q - 1));
                    pb[i] = int'($urandom_range(0, Q - 1));
                end
            end
            req_valid = pend;
            req_a = pk(pa[0], pa[1], pa[2], pa[3]);
            req_b = pk(pb[0], pb[1], pb[2], pb[3]);
            cycle();
            if (m_last_g >= 0) pend[m_last_g] = 1'b0;
        end
        req_valid = '0;
        repeat (8) cycle();
        chk("drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modmul_arb.md
# modmul_arb

Round-robin arbiter and sequencer that shares one pipelined Kyber modular multiplier (q = 3329, fixed latency, one issue per cycle) among N requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, steers its operands onto the multiplier inputs, and tracks each in-flight operation through a tag pipeline matched to the multiplier latency. It then returns every result, tagged with the originating requester index, on a shared registered response port. It sits between the NTT/polynomial-multiply control units and the shared modular multiplier.

## Interface
- N, default 4: number of requesters (2..8).
- IDW, default 2: requester id width, equal to ceil(log2(N)).
- LAT, default 3: multiplier latency in cycles, from operand-presentation cycle to result cycle.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester operand pair valid.
- req_ready  out  N  per-requester grant; one-hot or zero; combinational.
- req_a  in  12*N  operand A, requester i on bits [12i+11:12i]; value < 3329.
- req_b  in  12*N  operand B, same packing as req_a; value < 3329.
- mul_a  out  12  operand A to multiplier; combinational mux of the granted requester, 0 when idle.
- mul_b  out  12  operand B to multiplier; same rules as mul_a.
- mul_r  in  12  multiplier result, valid LAT cycles after presentation.
- rsp_valid  out  1  registered; result available this cycle.
- rsp_id  out  IDW  registered; originating requester index.
- rsp_r  out  12  registered; (A*B) mod 3329.
- busy  out  1  at least one operation in flight or a response pending.

## Operation
- Round-robin pointer ptr (IDW bits, reset 0).
- Grant selection: the first i with req_valid[i] = 1, scanning ptr, ptr+1, … modulo N.
- Handshake: the transfer happens in a cycle where req_valid[i] && req_ready[i]. At most one transfer per cycle.
- req_ready[i] depends on req_valid, never on req_ready.
- A requester holds req_a, req_b and req_valid stable until it sees ready.
- On transfer from i: ptr <= (i+1) mod N. With no transfer, ptr holds.
- Wrap-around: when ptr = N-1 and i < N-1 wins, ptr becomes i+1. When ptr = N-1 and i = N-1 wins, ptr becomes 0.
- Tag pipeline: LAT stages, each holding {valid, id}.
  - Stage 0 loads {transfer, granted id} every cycle.
  - Stage k loads stage k-1 every cycle.
  - Stage LAT-1 is therefore valid exactly in the cycle mul_r carries that result.
- Response register, every cycle:
  - rsp_valid <= stage[LAT-1].valid.
  - When stage[LAT-1].valid = 1: rsp_id <= stage[LAT-1].id and rsp_r <= mul_r.
  - Otherwise rsp_id and rsp_r hold their previous values.
- Responses have no backpressure. Consumers sink rsp_* whenever rsp_id matches.
- busy = OR of all tag valids | rsp_valid.
- No operand range checking. Inputs of 3329 or more produce undefined results but do not disturb the sequencing.

## Timing
- Reset values: ptr = 0, all tag valids = 0, rsp_valid = 0, rsp_id = 0, rsp_r = 0, busy = 0.
- During reset, req_ready = 0 and mul_a/mul_b = 0.
- Issue-to-response latency is LAT+1 cycles. A transfer in cycle c gives rsp_valid = 1 in cycle c+LAT+1 (c+4 by default).
- Throughput: one operation per cycle sustained. With all N requesting continuously, each requester gets exactly one grant per N cycles.
- Results return in issue order. Consecutive issues give consecutive response cycles.
- A transfer and a response in the same cycle are independent and both take effect.
- Reset mid-operation:
  - All in-flight tags are discarded; no rsp_valid is ever produced for them.
  - The multiplier's own pipeline is not reset by this block. Its stale outputs are ignored because the tags are cleared.
- Deasserting req_valid before ready is a protocol violation. The block does not need to handle it, but it must never grant a requester whose req_valid is 0.

## Test plan
- Single op: after reset, requester 0 presents a=3328, b=3328 for one cycle c. Expect rsp_valid at c+4 with rsp_id=0 and rsp_r=1; busy high for cycles c+1..c+4.
- Fairness: all 4 requesters valid continuously for 8 cycles with distinct operands, including a=1234, b=2 and a=3328, b=2. Expect grants 0,1,2,3,0,1,2,3 and correct id/result order. Requester 0 returns 2468 and requester 3 returns 3327.
- Pointer wrap: after a grant to 2 (ptr=3), only requesters 1 and 3 are valid. Expect grant 3, ptr=0, then grant 1.
- Idle gaps: requests in cycles 0, 2 and 5 only. Expect responses in cycles 4, 6 and 9, rsp_valid low in between, and rsp_r/rsp_id holding their values.
- Reset mid-flight: issue 3 back-to-back ops, then assert rst for 1 cycle after the second response cycle is reached. Expect no further rsp_valid, all outputs at reset values, and ptr=0 on release.
- Zero operand: a=0, b=2000. Expect rsp_r=0 after 4 cycles, and req_ready never asserted for invalid requesters.
